uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between two requesters, the arbiter and the UART transmit buffer.
// Master is the requester/buffer side; slave is the arbiter.
interface uart_tx_arbiter_if;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] data_tx;
    logic       utx_buffer_write;
    logic       utx_buffer_full;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req0_data, req0_valid, req0_last,
        output req1_data, req1_valid, req1_last,
        output utx_buffer_full,
        input  req0_ready, req1_ready,
        input  data_tx, utx_buffer_write, grant, busy
    );

    modport slave (
        input  req0_data, req0_valid, req0_last,
        input  req1_data, req1_valid, req1_last,
        input  utx_buffer_full,
        output req0_ready, req1_ready,
        output data_tx, utx_buffer_write, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a UART transmit buffer one byte at a time,
// holding each grant for a whole message, capped at MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    // Encoding matches the one-hot grant output directly.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_e;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       wr_q, wr_d;

    logic       ready0, ready1;
    logic       xfer;
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;
    logic [7:0] cnt_inc;

    always_comb begin
        // The write strobe gates ready so full always reflects the previous write.
        ready0    = (state_q == GRANT0) && !bus.utx_buffer_full && !wr_q;
        ready1    = (state_q == GRANT1) && !bus.utx_buffer_full && !wr_q;
        sel_valid = (state_q == GRANT1) ? bus.req1_valid : bus.req0_valid;
        sel_last  = (state_q == GRANT1) ? bus.req1_last  : bus.req0_last;
        sel_data  = (state_q == GRANT1) ? bus.req1_data  : bus.req0_data;
        xfer      = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
        cnt_inc   = cnt_q + 8'd1;

        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wr_d    = 1'b0;

        if (xfer) begin
            data_d = sel_data;
            wr_d   = 1'b1;
            cnt_d  = cnt_inc;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (bus.req0_valid && (!bus.req1_valid || !ptr_q))
                    state_d = GRANT0;
                else if (bus.req1_valid)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                // Leaving while a write is in flight is fine: wr_q completes regardless.
                if ((xfer && (sel_last || cnt_inc == BURST_MAX)) || (!sel_valid && !wr_q)) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == GRANT0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 8'd0;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.req0_ready       = ready0;
    assign bus.req1_ready       = ready1;
    assign bus.data_tx          = data_q;
    assign bus.utx_buffer_write = wr_q;
    assign bus.grant            = state_q;
    assign bus.busy             = (state_q != IDLE);
endmodule
